// File: rtl/a_arbiter_controller.sv
// Fixed-priority bus arbiter controller: grants one master at a time, drives the
// per-port cmd/done handshake and mux selects, and supports one level of preemption.
module a_arbiter_controller #(
  parameter int NO_MASTERS  = 2,
  parameter int NO_SLAVES   = 3,
  parameter int S_ID_WIDTH  = $clog2(NO_SLAVES + 1),
  parameter int ACK_TIMEOUT = 64,
  localparam int M_W        = (NO_MASTERS > 1) ? $clog2(NO_MASTERS) : 1,
  localparam int T_W        = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic [0:0]                       clk,
  input  logic [0:0]                       rst,
  input  logic [NO_MASTERS*S_ID_WIDTH-1:0] id,
  input  logic [NO_MASTERS*2-1:0]          com_state,
  output logic [NO_MASTERS*2-1:0]          cmd,
  output logic [NO_MASTERS-1:0]            done,
  output logic [0:0]                       bus_valid,
  output logic [M_W-1:0]                   m_sel,
  output logic [S_ID_WIDTH-1:0]            s_sel
);
  localparam logic [1:0] CS_END     = 2'b00;
  localparam logic [1:0] CS_NAK     = 2'b01;
  localparam logic [1:0] CS_COM     = 2'b11;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;
  localparam logic [1:0] CMD_STOP_S = 2'b01;
  localparam logic [1:0] CMD_STOP_P = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_BUSY     = 3'd3,
    ST_PREEMPT  = 3'd4,
    ST_RESUME   = 3'd5
  } state_t;

  // A slave id counts as a request only when it addresses an existing slave.
  function automatic logic req_ok(input logic [S_ID_WIDTH-1:0] sid);
    return (sid != '0) && (int'(sid) <= NO_SLAVES);
  endfunction

  function automatic logic [NO_MASTERS*2-1:0] put_cmd(input logic [M_W-1:0] m, input logic [1:0] code);
    logic [NO_MASTERS*2-1:0] v;
    v = '0;
    v[int'(m)*2 +: 2] = code;
    return v;
  endfunction

  function automatic logic [NO_MASTERS-1:0] onehot(input logic [M_W-1:0] m);
    logic [NO_MASTERS-1:0] v;
    v = '0;
    v[int'(m)] = 1'b1;
    return v;
  endfunction

  state_t                  state_r, state_s;
  logic [M_W-1:0]          owner_r, owner_s, susp_r, susp_s, pre_own_r, pre_own_s, win_s;
  logic [S_ID_WIDTH-1:0]   slave_r, slave_s, pre_sid_r, pre_sid_s;
  logic [S_ID_WIDTH-1:0]   sid_s [NO_MASTERS];
  logic [1:0]              cst_s [NO_MASTERS];
  logic [1:0]              own_cst_s;
  logic                    bus_valid_r, bus_valid_s, susp_vld_r, susp_vld_s;
  logic                    win_vld_s, any_end_s;
  logic [NO_MASTERS*2-1:0] cmd_r, cmd_s;
  logic [NO_MASTERS-1:0]   done_r, done_s;
  logic [T_W-1:0]          timer_r, timer_s;

  // Per-port decode: lowest-index valid request wins; flag any end_com.
  always_comb begin
    win_s     = '0;
    win_vld_s = 1'b0;
    any_end_s = 1'b0;
    for (int m = NO_MASTERS - 1; m >= 0; m--) begin
      sid_s[m]  = id[m*S_ID_WIDTH +: S_ID_WIDTH];
      cst_s[m]  = com_state[m*2 +: 2];
      win_s     = req_ok(sid_s[m]) ? M_W'(m) : win_s;
      win_vld_s = win_vld_s | req_ok(sid_s[m]);
      any_end_s = any_end_s | (cst_s[m] == CS_END);
    end
    own_cst_s = cst_s[owner_r];
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    slave_s     = slave_r;
    bus_valid_s = bus_valid_r;
    susp_s      = susp_r;
    susp_vld_s  = susp_vld_r;
    pre_own_s   = pre_own_r;
    pre_sid_s   = pre_sid_r;
    timer_s     = timer_r;
    cmd_s       = '0;
    done_s      = '0;
    case (state_r)
      ST_IDLE: begin
        if (win_vld_s) begin
          owner_s     = win_s;
          slave_s     = sid_s[win_s];
          cmd_s       = put_cmd(win_s, CMD_CLEAR);
          bus_valid_s = 1'b1;
          state_s     = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        timer_s = '0;
        state_s = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        timer_s = timer_r + T_W'(1);
        if (own_cst_s == CS_COM) begin
          state_s = ST_BUSY;
        end else if ((own_cst_s == CS_NAK) || (timer_r == T_W'(ACK_TIMEOUT - 1))) begin
          bus_valid_s = 1'b0;
          slave_s     = '0;
          if (susp_vld_r) begin
            done_s  = onehot(susp_r);
            state_s = ST_RESUME;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_WAIT_ACK;
        end
      end
      ST_BUSY: begin
        if (own_cst_s == CS_END) begin
          bus_valid_s = 1'b0;
          slave_s     = '0;
          if (susp_vld_r) begin
            done_s  = onehot(susp_r);
            state_s = ST_RESUME;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (win_vld_s && (win_s < owner_r) && !susp_vld_r && !any_end_s) begin
          // Split when the intruder wants a different slave, plain stop when it shares ours.
          cmd_s      = put_cmd(owner_r, (sid_s[win_s] != slave_r) ? CMD_STOP_S : CMD_STOP_P);
          susp_s     = owner_r;
          susp_vld_s = 1'b1;
          pre_own_s  = win_s;
          pre_sid_s  = sid_s[win_s];
          state_s    = ST_PREEMPT;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_PREEMPT: begin
        owner_s = pre_own_r;
        slave_s = pre_sid_r;
        cmd_s   = put_cmd(pre_own_r, CMD_CLEAR);
        state_s = ST_GRANT;
      end
      ST_RESUME: begin
        susp_vld_s = 1'b0;
        if (req_ok(sid_s[susp_r])) begin
          owner_s     = susp_r;
          slave_s     = sid_s[susp_r];
          cmd_s       = put_cmd(susp_r, CMD_CLEAR);
          bus_valid_s = 1'b1;
          state_s     = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        bus_valid_s = 1'b0;
        slave_s     = '0;
        susp_vld_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      owner_r     <= '0;
      slave_r     <= '0;
      bus_valid_r <= 1'b0;
      susp_r      <= '0;
      susp_vld_r  <= 1'b0;
      pre_own_r   <= '0;
      pre_sid_r   <= '0;
      timer_r     <= '0;
      cmd_r       <= '0;
      done_r      <= '0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      slave_r     <= slave_s;
      bus_valid_r <= bus_valid_s;
      susp_r      <= susp_s;
      susp_vld_r  <= susp_vld_s;
      pre_own_r   <= pre_own_s;
      pre_sid_r   <= pre_sid_s;
      timer_r     <= timer_s;
      cmd_r       <= cmd_s;
      done_r      <= done_s;
    end
  end

  assign cmd       = cmd_r;
  assign done      = done_r;
  assign bus_valid = bus_valid_r;
  assign m_sel     = owner_r;
  assign s_sel     = slave_r;

endmodule
